// File: rtl/memory_arbiter_if.sv
// Shared types and the cache/RAM-side bus of the memory arbiter.
package memory_arbiter_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic {IDLE, SERVE} arb_state_t;
  typedef enum logic [1:0] {IFETCH, DREAD, DWRITE} gtype_t;
endpackage

// Handshake: a cache raises iREN/dREN/dWEN with its address (and store data)
// and holds all of them stable until it sees its iwait/dwait low at a clock
// edge; wait low lasts exactly one cycle and marks the completing cycle, with
// iload/dload valid in that same cycle. On the RAM side ramREN/ramWEN act as
// valid and ramstate == ACCESS acts as ready; the access retires on the edge
// where both hold.
interface memory_arbiter_if #(parameter int CPUS = 2);
  import memory_arbiter_pkg::*;

  logic [CPUS-1:0]  iREN;
  logic [CPUS-1:0]  dREN;
  logic [CPUS-1:0]  dWEN;
  word_t [CPUS-1:0] iaddr;
  word_t [CPUS-1:0] daddr;
  word_t [CPUS-1:0] dstore;
  logic [CPUS-1:0]  iwait;
  logic [CPUS-1:0]  dwait;
  word_t [CPUS-1:0] iload;
  word_t [CPUS-1:0] dload;
  logic             ramREN;
  logic             ramWEN;
  word_t            ramaddr;
  word_t            ramstore;
  word_t            ramload;
  ramstate_t        ramstate;

  // Arbiter side.
  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // Caches plus RAM side.
  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter between per-core icache/dcache requesters and one
// single-ported RAM. One RAM transaction at a time; two-word dcache blocks
// are locked so no other requester slips between the words.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter  int CPUS = 2,
  localparam int PW   = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic             CLK,
  input  logic             nRST,
  memory_arbiter_if.slave  bus,
  output arb_state_t       state_o,
  output logic [PW-1:0]    gcpu_o,
  output gtype_t           gtype_o,
  output logic [PW-1:0]    rr_o
);

  arb_state_t state_q, state_d;
  logic [PW-1:0] gcpu_q, gcpu_d;
  gtype_t gtype_q, gtype_d;
  logic [PW-1:0] rr_q, rr_d;

  logic [CPUS-1:0]  iwait_c, dwait_c;
  word_t [CPUS-1:0] iload_c, dload_c;
  logic             ram_ren_c, ram_wen_c;
  word_t            ram_addr_c, ram_store_c;
  logic             gen_c;
  logic             found_c;
  logic [PW:0]      scan_sum_c;
  logic [PW-1:0]    scan_idx_c;
  logic [PW:0]      rr_sum_c;
  logic [PW-1:0]    rr_next_c;

  // Pointer to the core after the granted one, wrapping at CPUS.
  always_comb begin
    rr_sum_c = {1'b0, gcpu_q} + {{PW{1'b0}}, 1'b1};
    if (rr_sum_c >= (PW+1)'(CPUS)) begin
      rr_sum_c = '0;
    end
    rr_next_c = rr_sum_c[PW-1:0];
  end

  // Arbitration, RAM drive, completion routing and next-state selection.
  always_comb begin
    state_d     = state_q;
    gcpu_d      = gcpu_q;
    gtype_d     = gtype_q;
    rr_d        = rr_q;
    iwait_c     = '1;
    dwait_c     = '1;
    iload_c     = '0;
    dload_c     = '0;
    ram_ren_c   = 1'b0;
    ram_wen_c   = 1'b0;
    ram_addr_c  = '0;
    ram_store_c = '0;
    gen_c       = 1'b0;
    found_c     = 1'b0;
    scan_sum_c  = '0;
    scan_idx_c  = '0;

    case (state_q)
      IDLE: begin
        // First requesting core at or after rr wins; dWEN > dREN > iREN.
        for (int i = 0; i < CPUS; i++) begin
          scan_sum_c = {1'b0, rr_q} + (PW+1)'(i);
          if (scan_sum_c >= (PW+1)'(CPUS)) begin
            scan_sum_c = scan_sum_c - (PW+1)'(CPUS);
          end
          scan_idx_c = scan_sum_c[PW-1:0];
          if (!found_c && (bus.iREN[scan_idx_c] || bus.dREN[scan_idx_c] ||
                           bus.dWEN[scan_idx_c])) begin
            found_c = 1'b1;
            gcpu_d  = scan_idx_c;
            state_d = SERVE;
            if (bus.dWEN[scan_idx_c]) begin
              gtype_d = DWRITE;
            end else if (bus.dREN[scan_idx_c]) begin
              gtype_d = DREAD;
            end else begin
              gtype_d = IFETCH;
            end
          end
        end
      end

      SERVE: begin
        case (gtype_q)
          DWRITE:  gen_c = bus.dWEN[gcpu_q];
          DREAD:   gen_c = bus.dREN[gcpu_q];
          default: gen_c = bus.iREN[gcpu_q];
        endcase

        if (!gen_c) begin
          // Requester withdrew: drop the RAM access, keep rr where it was.
          state_d = IDLE;
        end else begin
          case (gtype_q)
            DWRITE: begin
              ram_wen_c   = 1'b1;
              ram_addr_c  = bus.daddr[gcpu_q];
              ram_store_c = bus.dstore[gcpu_q];
            end
            DREAD: begin
              ram_ren_c  = 1'b1;
              ram_addr_c = bus.daddr[gcpu_q];
            end
            default: begin
              ram_ren_c  = 1'b1;
              ram_addr_c = bus.iaddr[gcpu_q];
            end
          endcase

          // BUSY/FREE/ERROR all hold with wait high; ERROR is simply retried.
          if (bus.ramstate == ACCESS) begin
            if (gtype_q == IFETCH) begin
              iwait_c[gcpu_q] = 1'b0;
              iload_c[gcpu_q] = bus.ramload;
            end else begin
              dwait_c[gcpu_q] = 1'b0;
              if (gtype_q == DREAD) begin
                dload_c[gcpu_q] = bus.ramload;
              end
            end

            if (gtype_q != IFETCH && !ram_addr_c[2]) begin
              // First word of a dcache block: keep the grant for word two.
              if (bus.dWEN[gcpu_q]) begin
                gtype_d = DWRITE;
              end else if (bus.dREN[gcpu_q]) begin
                gtype_d = DREAD;
              end else begin
                state_d = IDLE;
                rr_d    = rr_next_c;
              end
            end else begin
              state_d = IDLE;
              rr_d    = rr_next_c;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      gcpu_q  <= '0;
      gtype_q <= IFETCH;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gcpu_q  <= gcpu_d;
      gtype_q <= gtype_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.iwait    = iwait_c;
  assign bus.dwait    = dwait_c;
  assign bus.iload    = iload_c;
  assign bus.dload    = dload_c;
  assign bus.ramREN   = ram_ren_c;
  assign bus.ramWEN   = ram_wen_c;
  assign bus.ramaddr  = ram_addr_c;
  assign bus.ramstore = ram_store_c;

  assign state_o = state_q;
  assign gcpu_o  = gcpu_q;
  assign gtype_o = gtype_q;
  assign rr_o    = rr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: cache models feed per-core op queues, a RAM model
// answers with configurable ERROR/BUSY latency, and every completion is popped
// against an expected queue holding {core, type, addr, data, cycle}.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int CPUS = 2;
  localparam int RW   = 83;
  localparam logic [1:0] T_IF = 2'd0;
  localparam logic [1:0] T_DR = 2'd1;
  localparam logic [1:0] T_DW = 2'd2;

  typedef struct packed {
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic nRST;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  memory_arbiter_if #(.CPUS(CPUS)) bus ();
  arb_state_t state_o;
  logic [0:0] gcpu_o;
  gtype_t     gtype_o;
  logic [0:0] rr_o;

  memory_arbiter #(.CPUS(CPUS)) dut (
    .CLK     (clk),
    .nRST    (nRST),
    .bus     (bus),
    .state_o (state_o),
    .gcpu_o  (gcpu_o),
    .gtype_o (gtype_o),
    .rr_o    (rr_o)
  );

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q[$];
  op_t iq0[$];
  op_t iq1[$];
  op_t dq0[$];
  op_t dq1[$];
  logic [31:0] mem [logic [31:0]];
  int vec_cnt   = 0;
  int err_cnt   = 0;
  int scyc      = 0;
  bit auto_mode = 1'b0;
  int busy_n    = 1;
  int err_n     = 0;
  int ram_cnt   = 0;

  task automatic check_eq(input string tag, input logic [RW-1:0] act,
                          input logic [RW-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk_rec(input logic core, input logic [1:0] typ,
                                           input logic [31:0] addr,
                                           input logic [31:0] data, input int cyc);
    return {core, typ, addr, data, 16'(cyc)};
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic expect_op(input logic core, input logic [1:0] typ,
                           input logic [31:0] addr, input logic [31:0] data,
                           input int cyc);
    exp_q.push_back(mk_rec(core, typ, addr, data, cyc));
  endtask

  function automatic op_t mk_op(input logic [1:0] typ, input logic [31:0] addr,
                                input logic [31:0] data);
    op_t o;
    o.typ  = typ;
    o.addr = addr;
    o.data = data;
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.iREN     = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.iaddr    = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  // Cache models: present the head of each queue until it completes.
  task automatic drive_caches();
    if (!auto_mode) return;
    bus.iREN = '0;
    bus.dREN = '0;
    bus.dWEN = '0;
    if (iq0.size() != 0) begin bus.iREN[0] = 1'b1; bus.iaddr[0] = iq0[0].addr; end
    if (iq1.size() != 0) begin bus.iREN[1] = 1'b1; bus.iaddr[1] = iq1[0].addr; end
    if (dq0.size() != 0) begin
      bus.dREN[0] = (dq0[0].typ == T_DR);
      bus.dWEN[0] = (dq0[0].typ == T_DW);
      bus.daddr[0] = dq0[0].addr;
      bus.dstore[0] = dq0[0].data;
    end
    if (dq1.size() != 0) begin
      bus.dREN[1] = (dq1[0].typ == T_DR);
      bus.dWEN[1] = (dq1[0].typ == T_DW);
      bus.daddr[1] = dq1[0].addr;
      bus.dstore[1] = dq1[0].data;
    end
  endtask

  // RAM model: ERROR for err_n cycles, BUSY for busy_n, then ACCESS.
  task automatic ram_model();
    if (bus.ramREN || bus.ramWEN) begin
      ram_cnt++;
      if (ram_cnt <= err_n) begin
        bus.ramstate = ERROR;
        bus.ramload  = 32'hCAFE_F00D;
      end else if (ram_cnt <= err_n + busy_n) begin
        bus.ramstate = BUSY;
        bus.ramload  = 32'hCAFE_F00D;
      end else begin
        bus.ramstate = ACCESS;
        bus.ramload  = bus.ramREN ? ram_rd(bus.ramaddr) : 32'hCAFE_F00D;
        if (bus.ramWEN) mem[bus.ramaddr] = bus.ramstore;
        ram_cnt = 0;
      end
    end else begin
      ram_cnt      = 0;
      bus.ramstate = FREE;
      bus.ramload  = 32'hCAFE_F00D;
    end
  endtask

  task automatic got(input logic [RW-1:0] r);
    if (exp_q.size() == 0) begin
      check_eq("spurious_done", r, '0);
    end else begin
      check_eq("completion", r, exp_q.pop_front());
    end
  endtask

  task automatic monitor();
    check_eq("ren_wen_excl", {1'b0, bus.ramREN & bus.ramWEN}, '0);
    for (int c = 0; c < CPUS; c++) begin
      if (bus.iwait[c]) check_eq("iload_idle", bus.iload[c], '0);
      if (bus.dwait[c]) check_eq("dload_idle", bus.dload[c], '0);
    end
    if (auto_mode) begin
      for (int c = 0; c < CPUS; c++) begin
        if (!bus.iwait[c]) begin
          got(mk_rec(c[0], T_IF, bus.ramaddr, bus.iload[c], scyc));
          if (c == 0 && iq0.size() != 0) void'(iq0.pop_front());
          if (c == 1 && iq1.size() != 0) void'(iq1.pop_front());
        end
        if (!bus.dwait[c]) begin
          got(mk_rec(c[0], bus.ramWEN ? T_DW : T_DR, bus.ramaddr,
                     bus.ramWEN ? bus.ramstore : bus.dload[c], scyc));
          if (c == 0 && dq0.size() != 0) void'(dq0.pop_front());
          if (c == 1 && dq1.size() != 0) void'(dq1.pop_front());
        end
      end
    end
  endtask

  // One clock: caches update just after the edge, RAM answers, sample at negedge.
  task automatic cycle();
    @(posedge clk);
    scyc++;
    #1;
    drive_caches();
    #1;
    ram_model();
    @(negedge clk);
    monitor();
  endtask

  task automatic reset_dut();
    auto_mode = 1'b0;
    clear_inputs();
    iq0.delete(); iq1.delete(); dq0.delete(); dq1.delete();
    exp_q.delete();
    nRST = 1'b0;
    repeat (2) cycle();
    nRST   = 1'b1;
    busy_n = 1;
    err_n  = 0;
  endtask

  task automatic start_auto();
    auto_mode = 1'b1;
    drive_caches();
    scyc = 0;
  endtask

  task automatic run_until_drained(input string tag, input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || iq0.size() != 0 || iq1.size() != 0 ||
            dq0.size() != 0 || dq1.size() != 0) && n < max_cyc) begin
      cycle();
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
    exp_q.delete();
    iq0.delete(); iq1.delete(); dq0.delete(); dq1.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d expected pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    nRST = 1'b0;
    clear_inputs();

    // Reset held with requests active, then release and reset mid-SERVE.
    bus.iREN = 2'b11;
    bus.dREN = 2'b11;
    bus.iaddr[0] = 32'h0000_1000;
    bus.daddr[0] = 32'h0000_2004;
    bus.iaddr[1] = 32'h0000_3000;
    bus.daddr[1] = 32'h0000_4004;
    busy_n = 2;
    repeat (3) begin
      cycle();
      check_eq("rst_iwait", bus.iwait, 2'b11);
      check_eq("rst_dwait", bus.dwait, 2'b11);
      check_eq("rst_ramen", {bus.ramREN, bus.ramWEN}, 2'b00);
      check_eq("rst_loads", {bus.iload, bus.dload}, '0);
      check_eq("rst_state", state_o, IDLE);
    end
    nRST = 1'b1;
    cycle();
    check_eq("rel_ramren", bus.ramREN, 1'b1);
    check_eq("rel_ramaddr", bus.ramaddr, 32'h0000_2004);
    check_eq("rel_gtype", gtype_o, DREAD);
    check_eq("rel_gcpu", gcpu_o, 1'b0);
    nRST = 1'b0;
    cycle();
    check_eq("midrst_state", state_o, IDLE);
    check_eq("midrst_ramren", bus.ramREN, 1'b0);
    check_eq("midrst_dwait", bus.dwait, 2'b11);

    // Single fetch with two BUSY cycles.
    reset_dut();
    busy_n = 2;
    mem[32'h0000_0040] = 32'hDEAD_BEEF;
    iq0.push_back(mk_op(T_IF, 32'h0000_0040, 32'h0));
    expect_op(1'b0, T_IF, 32'h0000_0040, 32'hDEAD_BEEF, 3);
    start_auto();
    run_until_drained("drain_fetch", 40);
    cycle();
    check_eq("fetch_rr", rr_o, 1'b1);
    check_eq("fetch_idle", state_o, IDLE);

    // Data read beats instruction fetch within a core, one IDLE gap between.
    reset_dut();
    iq0.push_back(mk_op(T_IF, 32'h0000_0080, 32'h0));
    dq0.push_back(mk_op(T_DR, 32'h0000_0204, 32'h0));
    expect_op(1'b0, T_DR, 32'h0000_0204, ram_rd(32'h0000_0204), 2);
    expect_op(1'b0, T_IF, 32'h0000_0080, ram_rd(32'h0000_0080), 5);
    start_auto();
    run_until_drained("drain_prio", 40);

    // Round-robin between two cores fetching continuously.
    reset_dut();
    iq0.push_back(mk_op(T_IF, 32'h0000_0010, 32'h0));
    iq0.push_back(mk_op(T_IF, 32'h0000_0014, 32'h0));
    iq1.push_back(mk_op(T_IF, 32'h0000_0020, 32'h0));
    iq1.push_back(mk_op(T_IF, 32'h0000_0024, 32'h0));
    expect_op(1'b0, T_IF, 32'h0000_0010, ram_rd(32'h0000_0010), 2);
    expect_op(1'b1, T_IF, 32'h0000_0020, ram_rd(32'h0000_0020), 5);
    expect_op(1'b0, T_IF, 32'h0000_0014, ram_rd(32'h0000_0014), 8);
    expect_op(1'b1, T_IF, 32'h0000_0024, ram_rd(32'h0000_0024), 11);
    start_auto();
    run_until_drained("drain_rr", 60);
    cycle();
    check_eq("rr_wrap", rr_o, 1'b0);

    // Locked two-word write from core1 while core0 waits; core0 reads it back.
    reset_dut();
    dq1.push_back(mk_op(T_DW, 32'h0000_0100, 32'h1111_0100));
    dq1.push_back(mk_op(T_DW, 32'h0000_0104, 32'h2222_0104));
    expect_op(1'b1, T_DW, 32'h0000_0100, 32'h1111_0100, 2);
    expect_op(1'b1, T_DW, 32'h0000_0104, 32'h2222_0104, 4);
    expect_op(1'b0, T_IF, 32'h0000_0104, 32'h2222_0104, 7);
    start_auto();
    cycle();
    iq0.push_back(mk_op(T_IF, 32'h0000_0104, 32'h0));
    drive_caches();
    run_until_drained("drain_lock", 60);

    // Three ERROR cycles are retried silently before ACCESS.
    reset_dut();
    err_n  = 3;
    busy_n = 0;
    dq0.push_back(mk_op(T_DR, 32'h0000_0304, 32'h0));
    expect_op(1'b0, T_DR, 32'h0000_0304, ram_rd(32'h0000_0304), 4);
    start_auto();
    run_until_drained("drain_error", 40);

    // Randomised independent reads, one core at a time, spacing checked.
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      int bn;
      reset_dut();
      bn = $urandom_range(0, 3);
      busy_n = bn;
      a = {20'h0, 4'($urandom_range(0, 15)), 8'h04};
      dq1.push_back(mk_op(T_DR, a, 32'h0));
      expect_op(1'b1, T_DR, a, ram_rd(a), bn + 1);
      start_auto();
      run_until_drained("drain_rand", 40);
    end

    // Abort: request withdrawn during BUSY.
    reset_dut();
    busy_n = 3;
    bus.dREN[0] = 1'b1;
    bus.daddr[0] = 32'h0000_0404;
    cycle();
    check_eq("abort_en", bus.ramREN, 1'b1);
    bus.dREN[0] = 1'b0;
    #1;
    check_eq("abort_drop", bus.ramREN, 1'b0);
    cycle();
    check_eq("abort_state", state_o, IDLE);
    check_eq("abort_rr", rr_o, 1'b0);
    check_eq("abort_dwait", bus.dwait, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
